rf_write_arbiter: RTL

//  Shares the single register-file write port between in-order pipeline writeback (WB) and a

---
 rtl/rf_write_arbiter.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter
//   Shares the single register-file write port between in-order pipeline
//   writeback (WB) and a multi-cycle unit (MC) that completes out of band.
//   MC results are buffered in a small FIFO. A busy scoreboard tracks registers
//   that still have an MC result outstanding. When the FIFO head has waited too
//   long, pipe_stall forces a WB bubble so that the head can drain.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   wb_valid/addr/data       pipeline writeback request (never back-pressured)
//   mc_valid/addr/data       MC result offer
//   mc_ready                 FIFO can accept (from registered occupancy only)
//   iss_valid/addr           long-latency op issued; marks iss_addr busy
//   busy_vec                 registers with an outstanding MC result (bit 0 = 0)
//   pipe_stall               registered; pipeline must hold wb_valid low
//   rf_wr_en/addr/data       register-file write port
module rf_write_arbiter #(
  parameter int XLEN         = 64,
  parameter int NREG         = 32,
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4,
  localparam int AW          = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wb_valid,
  input  logic [AW-1:0]   wb_addr,
  input  logic [XLEN-1:0] wb_data,
  input  logic            mc_valid,
  output logic            mc_ready,
  input  logic [AW-1:0]   mc_addr,
  input  logic [XLEN-1:0] mc_data,
  input  logic            iss_valid,
  input  logic [AW-1:0]   iss_addr,
  output logic [NREG-1:0] busy_vec,
  output logic            pipe_stall,
  output logic            rf_wr_en,
  output logic [AW-1:0]   rf_wr_addr,
  output logic [XLEN-1:0] rf_wr_data
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [AW-1:0]   fifo_addr [FIFO_DEPTH];
  logic [XLEN-1:0] fifo_data [FIFO_DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [CW-1:0]   count;
  logic [SW-1:0]   starve_cnt;
  logic [SW-1:0]   starve_next;
  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_next;

  logic            fifo_empty;
  logic            fifo_full;
  logic            push;
  logic            pop;
  logic            grant_wb;
  logic            grant_fifo;
  logic [AW-1:0]   head_addr;
  logic [XLEN-1:0] head_data;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CW'(FIFO_DEPTH));
  assign head_addr  = fifo_addr[rd_ptr];
  assign head_data  = fifo_data[rd_ptr];

  // Readiness depends only on registered occupancy, so a same-cycle pop never
  // opens a slot for a same-cycle push.
  assign mc_ready = !rst && !fifo_full;
  assign push     = mc_valid && mc_ready;

  // Port grant. A stalled pipeline hands the port to the starving head; WB
  // presented during a stall is a protocol error and is dropped.
  always_comb begin
    grant_wb   = 1'b0;
    grant_fifo = 1'b0;
    if (!rst) begin
      if (pipe_stall && !fifo_empty) begin
        grant_fifo = 1'b1;
      end else if (wb_valid && (wb_addr != '0) && !pipe_stall) begin
        grant_wb = 1'b1;
      end else if (!fifo_empty) begin
        grant_fifo = 1'b1;
      end
    end
  end

  // A granted head is always popped, even when it targets x0 and is discarded.
  assign pop = grant_fifo;

  always_comb begin
    rf_wr_en   = 1'b0;
    rf_wr_addr = '0;
    rf_wr_data = '0;
    if (grant_wb) begin
      rf_wr_en   = 1'b1;
      rf_wr_addr = wb_addr;
      rf_wr_data = wb_data;
    end else if (grant_fifo && (head_addr != '0)) begin
      rf_wr_en   = 1'b1;
      rf_wr_addr = head_addr;
      rf_wr_data = head_data;
    end
  end

  always_comb begin
    starve_next = '0;
    if (!fifo_empty && !pop) begin
      if (starve_cnt >= SW'(STARVE_LIMIT)) begin
        starve_next = starve_cnt;
      end else begin
        starve_next = starve_cnt + SW'(1);
      end
    end
  end

  // Clear on pop first so that a same-cycle issue to the same register wins.
  always_comb begin
    busy_next = busy_q;
    if (pop) begin
      busy_next[head_addr] = 1'b0;
    end
    if (iss_valid && (iss_addr != '0)) begin
      busy_next[iss_addr] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      starve_cnt <= '0;
      pipe_stall <= 1'b0;
      busy_q     <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      starve_cnt <= starve_next;
      pipe_stall <= (starve_next >= SW'(STARVE_LIMIT));
      busy_q     <= busy_next;
    end
  end

  // Payload storage needs no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= mc_addr;
      fifo_data[wr_ptr] <= mc_data;
    end
  end

  assign busy_vec = busy_q;

  wb_during_stall: assert property (@(posedge clk) disable iff (rst) !(pipe_stall && wb_valid));

endmodule
